// File: rtl/usr_param_if.sv
// Command/status bundle for the usr_param universal shift register.
// The controller drives the command side (master); the register answers on the status side (slave).
interface usr_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             s_left;
    logic             s_right;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] out;
    logic             so_left;
    logic             so_right;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, amt, s_left, s_right, p_in,
        input  out, so_left, so_right, busy, done
    );

    modport slave (
        input  start, mode, amt, s_left, s_right, p_in,
        output out, so_left, so_right, busy, done
    );
endinterface

// File: rtl/usr_param.sv
// Parametrised universal shift register executing multi-step commands one bit per cycle.
// Define USR_ROTATE_EN to build the rotate opcodes; otherwise they act as a single-cycle hold.
module usr_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    usr_param_if.slave  bus
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_remaining;
    logic [WIDTH-1:0] r_out;
    logic             r_busy;
    logic             r_done;

    // One step of a multi-step opcode; opcodes without a step leave the value alone.
    function automatic logic [WIDTH-1:0] f_step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] res;
        res = v;
        case (m)
            MODE_SHL: res = {v[WIDTH-2:0], sl};
            MODE_SHR: res = {sr, v[WIDTH-1:1]};
            MODE_ASR: res = {v[WIDTH-1], v[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            MODE_ROL: res = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR: res = {v[0], v[WIDTH-1:1]};
`endif
            default:  res = v;
        endcase
        return res;
    endfunction

    function automatic logic f_is_step(input logic [2:0] m);
        logic res;
        case (m)
            MODE_SHL, MODE_SHR, MODE_ASR: res = 1'b1;
`ifdef USR_ROTATE_EN
            MODE_ROL, MODE_ROR:           res = 1'b1;
`endif
            default:                      res = 1'b0;
        endcase
        return res;
    endfunction

    // Result of the single-cycle opcodes (hold, load, clear, and rotates when not built).
    function automatic logic [WIDTH-1:0] f_single(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] p
    );
        logic [WIDTH-1:0] res;
        case (m)
            MODE_LOAD: res = p;
            MODE_CLR:  res = '0;
            MODE_HOLD: res = v;
            default:   res = v;
        endcase
        return res;
    endfunction

    // Command FSM: first step happens on the accepting edge, RUN covers steps 2..N.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_HOLD;
            r_remaining <= '0;
            r_out       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        if (!f_is_step(bus.mode)) begin
                            r_out  <= f_single(bus.mode, r_out, bus.p_in);
                            r_done <= 1'b1;
                        end else if (bus.amt == '0) begin
                            r_done <= 1'b1;
                        end else if (bus.amt == AMT_W'(1)) begin
                            r_out  <= f_step(bus.mode, r_out, bus.s_left, bus.s_right);
                            r_done <= 1'b1;
                        end else begin
                            r_out       <= f_step(bus.mode, r_out, bus.s_left, bus.s_right);
                            r_remaining <= bus.amt - AMT_W'(1);
                            r_busy      <= 1'b1;
                            r_state     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_out       <= f_step(r_mode, r_out, bus.s_left, bus.s_right);
                    r_remaining <= r_remaining - AMT_W'(1);
                    if (r_remaining == AMT_W'(1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out      = r_out;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.so_left  = r_out[WIDTH-1];
    assign bus.so_right = r_out[0];

endmodule

// File: tb/tb_usr_param.sv
// Directed self-checking bench for usr_param at WIDTH=8, AMT_W=4.
// Expectations for opcodes 101/110 follow whether USR_ROTATE_EN is defined.
module tb_usr_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    usr_param_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    usr_param #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command, then count edges until done (bounded); start is held for E0 only.
    task automatic run_cmd(input logic [2:0] m, input logic [AMT_W-1:0] a,
                           input logic [WIDTH-1:0] p, output int edges);
        bus.mode  = m;
        bus.amt   = a;
        bus.p_in  = p;
        bus.start = 1'b1;
        edges     = 0;
        do begin
            tick();
            bus.start = 1'b0;
            edges++;
        end while (!bus.done && edges < 40);
    endtask

    // Busy and done must never overlap.
    always @(negedge clk) begin
        if (!rst && n_checks > 0)
            check("busy_done_excl", {31'b0, bus.busy & bus.done}, 32'h0);
    end

    initial begin
        int e;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.mode    = 3'b000;
        bus.amt     = '0;
        bus.s_left  = 1'b0;
        bus.s_right = 1'b0;
        bus.p_in    = '0;
        tick(); tick();

        // Reset state, and reset beats start on the same edge.
        check("rst_out",  {24'h0, bus.out}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        bus.start = 1'b1; bus.mode = 3'b011; bus.p_in = 8'hAA;
        tick();
        bus.start = 1'b0;
        check("rst_prio_out",  {24'h0, bus.out}, 32'h0);
        check("rst_prio_done", {31'h0, bus.done}, 32'h0);
        rst = 1'b0;
        tick();

        // Load
        bus.start = 1'b1; bus.mode = 3'b011; bus.p_in = 8'hA5;
        tick();
        bus.start = 1'b0;
        check("load_out",  {24'h0, bus.out}, 32'hA5);
        check("load_done", {31'h0, bus.done}, 32'h1);
        check("load_busy", {31'h0, bus.busy}, 32'h0);
        check("so_left_a5",  {31'h0, bus.so_left}, 32'h1);
        check("so_right_a5", {31'h0, bus.so_right}, 32'h1);
        tick();
        check("load_done_1cyc", {31'h0, bus.done}, 32'h0);

        // Shift left by 3 with s_left=1
        bus.start = 1'b1; bus.mode = 3'b001; bus.amt = 4'd3; bus.s_left = 1'b1;
        tick();
        bus.start = 1'b0;
        check("shl_e0_out", {24'h0, bus.out}, 32'h4B);
        check("shl_e0_busy", {31'h0, bus.busy}, 32'h1);
        check("shl_e0_so", {31'h0, bus.so_left}, 32'h0);
        tick();
        check("shl_e1_out", {24'h0, bus.out}, 32'h97);
        check("shl_e1_busy", {31'h0, bus.busy}, 32'h1);
        check("shl_e1_done", {31'h0, bus.done}, 32'h0);
        check("shl_e1_so", {31'h0, bus.so_left}, 32'h1);
        tick();
        check("shl_e2_out", {24'h0, bus.out}, 32'h2F);
        check("shl_e2_busy", {31'h0, bus.busy}, 32'h0);
        check("shl_e2_done", {31'h0, bus.done}, 32'h1);
        check("shl_e2_so", {31'h0, bus.so_left}, 32'h0);
        tick();
        check("shl_done_drop", {31'h0, bus.done}, 32'h0);

        // ASR by 2, then back-to-back ASR by 15 issued in the done cycle
        run_cmd(3'b011, 4'd0, 8'h90, e);
        bus.start = 1'b1; bus.mode = 3'b100; bus.amt = 4'd2;
        tick();
        bus.start = 1'b0;
        check("asr_e0_out", {24'h0, bus.out}, 32'hC8);
        tick();
        check("asr_e1_out", {24'h0, bus.out}, 32'hE4);
        check("asr_e1_done", {31'h0, bus.done}, 32'h1);
        run_cmd(3'b100, 4'd15, 8'h00, e);
        check("asr15_edges", e, 32'd15);
        check("asr15_out", {24'h0, bus.out}, 32'hFF);

        // Rotate right by 4
        run_cmd(3'b011, 4'd0, 8'h3C, e);
        run_cmd(3'b110, 4'd4, 8'h00, e);
`ifdef USR_ROTATE_EN
        check("ror_edges", e, 32'd4);
        check("ror_out", {24'h0, bus.out}, 32'hC3);
`else
        check("ror_off_edges", e, 32'd1);
        check("ror_off_out", {24'h0, bus.out}, 32'h3C);
`endif

        // Load during a 5-step left shift is ignored
        run_cmd(3'b011, 4'd0, 8'h81, e);
        check("so_right_81", {31'h0, bus.so_right}, 32'h1);
        bus.s_left = 1'b0;
        bus.start = 1'b1; bus.mode = 3'b001; bus.amt = 4'd5;
        tick();
        bus.mode = 3'b011; bus.p_in = 8'hFF; bus.amt = 4'd1;
        tick();
        bus.start = 1'b0;
        e = 2;
        while (!bus.done && e < 40) begin
            tick();
            e++;
        end
        check("ign_edges", e, 32'd5);
        check("ign_out", {24'h0, bus.out}, 32'h20);

        // amt=0 step command leaves out alone
        run_cmd(3'b001, 4'd0, 8'h00, e);
        check("amt0_edges", e, 32'd1);
        check("amt0_out", {24'h0, bus.out}, 32'h20);
        check("amt0_busy", {31'h0, bus.busy}, 32'h0);

        // Logical right shift by 2 with s_right=1
        bus.s_right = 1'b1;
        run_cmd(3'b010, 4'd2, 8'h00, e);
        check("shr_edges", e, 32'd2);
        check("shr_out", {24'h0, bus.out}, 32'hC8);

        // Clear
        run_cmd(3'b111, 4'd0, 8'h00, e);
        check("clr_edges", e, 32'd1);
        check("clr_out", {24'h0, bus.out}, 32'h0);

        // Reset on the 2nd step of a 6-step shift aborts it
        run_cmd(3'b011, 4'd0, 8'hFF, e);
        bus.start = 1'b1; bus.mode = 3'b001; bus.amt = 4'd6; bus.s_left = 1'b0;
        tick();
        bus.start = 1'b0;
        check("abort_e0_out", {24'h0, bus.out}, 32'hFE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out",  {24'h0, bus.out}, 32'h0);
        check("abort_busy", {31'h0, bus.busy}, 32'h0);
        check("abort_done", {31'h0, bus.done}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("abort_no_done", {31'h0, bus.done}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
